// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the execute-stage HI/LO unit:
//   - funct field codes for the HI/LO-writing instructions
//   - the decoder strobe value that means "write"
//   - the HI/LO unit FSM state type
// ---------------------------------------------------------------------------
package mips_pkg;

   localparam logic [5:0] FUNCT_MULT  = 6'h18;
   localparam logic [5:0] FUNCT_MULTU = 6'h19;
   localparam logic [5:0] FUNCT_DIV   = 6'h1A;
   localparam logic [5:0] FUNCT_DIVU  = 6'h1B;
   localparam logic [5:0] FUNCT_MTHI  = 6'h11;
   localparam logic [5:0] FUNCT_MTLO  = 6'h13;

   localparam logic [1:0] HILO_WRITE_EN = 2'b11;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      DIV_RUN = 2'd1,
      DIV_FIX = 2'd2
   } muldiv_state_t;

endpackage

// File: rtl/hilo_divider_core.sv
// ---------------------------------------------------------------------------
// hilo_divider_core
// Iterative restoring divider working on operand magnitudes, one quotient
// bit per cycle, WIDTH cycles per divide. Sign correction is left to the
// caller, which receives the latched q_neg / r_neg flags.
//
// Ports:
//   clk, reset    clock, synchronous active-high reset
//   start_i       latch operands (magnitudes) and clear the step counter
//   run_i         perform one shift-subtract step this cycle
//   signed_i      operands are two's complement (DIV) rather than raw (DIVU)
//   dividend_i    dividend, sampled on start_i
//   divisor_i     divisor, sampled on start_i
//   done_o        high during the final step (counter = WIDTH-1)
//   q_o, r_o      unsigned quotient / remainder magnitudes
//   q_neg_o       quotient must be negated
//   r_neg_o       remainder must be negated
// ---------------------------------------------------------------------------
module hilo_divider_core #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_i,
   input  logic             run_i,
   input  logic             signed_i,
   input  logic [WIDTH-1:0] dividend_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic             done_o,
   output logic [WIDTH-1:0] q_o,
   output logic [WIDTH-1:0] r_o,
   output logic             q_neg_o,
   output logic             r_neg_o
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quot_q, quot_d;
   logic [WIDTH-1:0] dvsr_q, dvsr_d;
   logic             q_neg_q, q_neg_d;
   logic             r_neg_q, r_neg_d;

   logic             dvnd_neg, dvsr_neg;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH:0]   diff;

   assign dvnd_neg = signed_i & dividend_i[WIDTH-1];
   assign dvsr_neg = signed_i & divisor_i[WIDTH-1];

   // The quotient register starts out holding the dividend; its MSB is shifted
   // into the partial remainder each step while the new quotient bit enters at
   // the LSB. A divisor of zero makes every trial subtract succeed, which
   // yields q = all ones and r = dividend without any special case.
   assign rem_sh = {rem_q, quot_q[WIDTH-1]};
   assign diff   = rem_sh - {1'b0, dvsr_q};

   always_comb begin
      count_d = count_q;
      rem_d   = rem_q;
      quot_d  = quot_q;
      dvsr_d  = dvsr_q;
      q_neg_d = q_neg_q;
      r_neg_d = r_neg_q;
      if (start_i) begin
         count_d = '0;
         rem_d   = '0;
         quot_d  = dvnd_neg ? -dividend_i : dividend_i;
         dvsr_d  = dvsr_neg ? -divisor_i  : divisor_i;
         q_neg_d = dvnd_neg ^ dvsr_neg;
         r_neg_d = dvnd_neg;
      end else if (run_i) begin
         if (!diff[WIDTH]) begin
            rem_d  = diff[WIDTH-1:0];
            quot_d = {quot_q[WIDTH-2:0], 1'b1};
         end else begin
            rem_d  = rem_sh[WIDTH-1:0];
            quot_d = {quot_q[WIDTH-2:0], 1'b0};
         end
         if (count_q != LAST_STEP) begin
            count_d = count_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
         rem_q   <= '0;
         quot_q  <= '0;
         dvsr_q  <= '0;
         q_neg_q <= 1'b0;
         r_neg_q <= 1'b0;
      end else begin
         count_q <= count_d;
         rem_q   <= rem_d;
         quot_q  <= quot_d;
         dvsr_q  <= dvsr_d;
         q_neg_q <= q_neg_d;
         r_neg_q <= r_neg_d;
      end
   end

   assign done_o  = run_i & (count_q == LAST_STEP);
   assign q_o     = quot_q;
   assign r_o     = rem_q;
   assign q_neg_o = q_neg_q;
   assign r_neg_o = r_neg_q;

endmodule

// File: rtl/hilo_muldiv_unit.sv
// ---------------------------------------------------------------------------
// hilo_muldiv_unit
// Execute-stage HI/LO unit. Owns the architectural HI and LO registers,
// performs MULT/MULTU in one cycle, DIV/DIVU over WIDTH+1 cycles through
// hilo_divider_core, and MTHI/MTLO in one cycle.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   clk_en              CPU advance enable; gates acceptance of new operations
//   funct               instruction funct field
//   HI_write, LO_write  decoder strobes, 2'b11 means write
//   hilo_read           current instruction is MFHI/MFLO
//   rs_data, rt_data    operands
//   hi, lo              HI / LO registers to the writeback mux
//   busy                divide in flight (DIV_RUN or DIV_FIX)
//   stall               CPU must hold the current instruction
//   state_o             FSM state, for observation
//
// Handshake: a request is accepted only at an edge where it is presented
// with clk_en high and busy low. While busy, any request (or an MFHI/MFLO
// read) raises stall combinationally and the CPU keeps re-presenting it.
// ---------------------------------------------------------------------------
module hilo_muldiv_unit
   import mips_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clk_en,
   input  logic [5:0]       funct,
   input  logic [1:0]       HI_write,
   input  logic [1:0]       LO_write,
   input  logic             hilo_read,
   input  logic [WIDTH-1:0] rs_data,
   input  logic [WIDTH-1:0] rt_data,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             stall,
   output muldiv_state_t    state_o
);

   muldiv_state_t    state_q;
   logic [WIDTH-1:0] hi_q, lo_q;
   logic             busy_q;

   logic             hi_wr, lo_wr;
   logic             req_mul, req_div, req_mthi, req_mtlo;
   logic             mul_signed, div_signed;
   logic [2*WIDTH-1:0] mul_a, mul_b, product;

   logic             div_start, div_run, div_done;
   logic [WIDTH-1:0] div_q, div_r;
   logic             div_q_neg, div_r_neg;

   // ---------------- request decode ----------------
   assign hi_wr    = clk_en & (HI_write == HILO_WRITE_EN);
   assign lo_wr    = clk_en & (LO_write == HILO_WRITE_EN);
   assign req_mul  = hi_wr & lo_wr & ((funct == FUNCT_MULT) | (funct == FUNCT_MULTU));
   assign req_div  = hi_wr & lo_wr & ((funct == FUNCT_DIV)  | (funct == FUNCT_DIVU));
   assign req_mthi = hi_wr & (funct == FUNCT_MTHI);
   assign req_mtlo = lo_wr & (funct == FUNCT_MTLO);

   assign mul_signed = (funct == FUNCT_MULT);
   assign div_signed = (funct == FUNCT_DIV);

   assign stall = busy_q & (hilo_read | req_mul | req_div | req_mthi | req_mtlo);

   // ---------------- multiplier ----------------
   // Extending both operands to 2*WIDTH and keeping the low 2*WIDTH bits of
   // the product gives the correct signed or unsigned result.
   assign mul_a   = mul_signed ? {{WIDTH{rs_data[WIDTH-1]}}, rs_data} : {{WIDTH{1'b0}}, rs_data};
   assign mul_b   = mul_signed ? {{WIDTH{rt_data[WIDTH-1]}}, rt_data} : {{WIDTH{1'b0}}, rt_data};
   assign product = mul_a * mul_b;

   // ---------------- divider ----------------
   assign div_start = (state_q == IDLE) & req_div;
   assign div_run   = (state_q == DIV_RUN);

   hilo_divider_core #(
      .WIDTH(WIDTH)
   ) u_div (
      .clk        (clk),
      .reset      (reset),
      .start_i    (div_start),
      .run_i      (div_run),
      .signed_i   (div_signed),
      .dividend_i (rs_data),
      .divisor_i  (rt_data),
      .done_o     (div_done),
      .q_o        (div_q),
      .r_o        (div_r),
      .q_neg_o    (div_q_neg),
      .r_neg_o    (div_r_neg)
   );

   // ---------------- FSM and HI/LO registers ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         hi_q    <= '0;
         lo_q    <= '0;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_mul) begin
                  {hi_q, lo_q} <= product;
               end else if (req_div) begin
                  state_q <= DIV_RUN;
                  busy_q  <= 1'b1;
               end else begin
                  if (req_mthi) hi_q <= rs_data;
                  if (req_mtlo) lo_q <= rs_data;
               end
            end
            DIV_RUN: begin
               // Steps advance regardless of clk_en so a divide always
               // finishes in a fixed number of cycles.
               if (div_done) state_q <= DIV_FIX;
            end
            DIV_FIX: begin
               lo_q    <= div_q_neg ? -div_q : div_q;
               hi_q    <= div_r_neg ? -div_r : div_r;
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign hi      = hi_q;
   assign lo      = lo_q;
   assign busy    = busy_q;
   assign state_o = state_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
module tb_hilo_muldiv_unit;
   import mips_pkg::*;

   localparam int WIDTH = 32;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              reset;
   logic              clk_en;
   logic [5:0]        funct;
   logic [1:0]        HI_write, LO_write;
   logic              hilo_read;
   logic [WIDTH-1:0]  rs_data, rt_data;
   logic [WIDTH-1:0]  hi, lo;
   logic              busy, stall;
   muldiv_state_t     state_o;

   int pass_cnt  = 0;
   int total_cnt = 0;

   hilo_muldiv_unit #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .clk_en    (clk_en),
      .funct     (funct),
      .HI_write  (HI_write),
      .LO_write  (LO_write),
      .hilo_read (hilo_read),
      .rs_data   (rs_data),
      .rt_data   (rt_data),
      .hi        (hi),
      .lo        (lo),
      .busy      (busy),
      .stall     (stall),
      .state_o   (state_o)
   );

   // ---------------- driver tasks (called at negedge) ----------------
   task automatic clear_req();
      funct     = 6'h00;
      HI_write  = 2'b00;
      LO_write  = 2'b00;
      hilo_read = 1'b0;
      rs_data   = '0;
      rt_data   = '0;
   endtask

   task automatic issue(input logic [5:0] f, input logic [1:0] hw, input logic [1:0] lw,
                        input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      funct    = f;
      HI_write = hw;
      LO_write = lw;
      rs_data  = a;
      rt_data  = b;
   endtask

   // Issues a divide, then follows it until busy drops (bounded).
   // mode 1: MFHI held from busy cycle 2; mode 2: MTHI presented from busy
   // cycle 5; mode 3: clk_en low from busy cycle 3.
   task automatic run_div(input logic [5:0] f, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input int mode, output int cycles, output int stall_bad, output int hi_moved);
      logic [WIDTH-1:0] hi_before;
      issue(f, 2'b11, 2'b11, a, b);
      @(negedge clk);
      clear_req();
      hi_before = hi;
      cycles    = 0;
      stall_bad = 0;
      hi_moved  = 0;
      while (busy === 1'b1 && cycles < 100) begin
         cycles++;
         if (mode == 1 && cycles == 2) hilo_read = 1'b1;
         if (mode == 2 && cycles == 5) issue(FUNCT_MTHI, 2'b11, 2'b00, 32'h12345678, 32'h0);
         if (mode == 3 && cycles == 3) clk_en = 1'b0;
         #1;
         if ((mode == 1 && cycles >= 2) || (mode == 2 && cycles >= 5))
            if (stall !== 1'b1) stall_bad++;
         if (hi !== hi_before) hi_moved++;
         @(negedge clk);
      end
      clk_en = 1'b1;
      #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset  = 1'b1;
      clk_en = 1'b1;
      clear_req();
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      total_cnt++; if (hi !== 32'h0) $display("FAIL reset_hi: got %h want %h", hi, 32'h0); else pass_cnt++;
      total_cnt++; if (lo !== 32'h0) $display("FAIL reset_lo: got %h want %h", lo, 32'h0); else pass_cnt++;
      total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
      total_cnt++; if (stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", stall); else pass_cnt++;
      total_cnt++; if (state_o !== IDLE) $display("FAIL reset_state: got %0d want %0d", state_o, IDLE); else pass_cnt++;
   endtask

   task automatic test_mult();
      @(negedge clk);
      issue(FUNCT_MULT, 2'b11, 2'b11, 32'hFFFFFFFE, 32'h00000003);
      @(negedge clk);
      clear_req();
      #1;
      total_cnt++; if (hi !== 32'hFFFFFFFF) $display("FAIL mult_hi: got %h want %h", hi, 32'hFFFFFFFF); else pass_cnt++;
      total_cnt++; if (lo !== 32'hFFFFFFFA) $display("FAIL mult_lo: got %h want %h", lo, 32'hFFFFFFFA); else pass_cnt++;
      total_cnt++; if (busy !== 1'b0) $display("FAIL mult_busy: got %b want 0", busy); else pass_cnt++;
      @(negedge clk);
      issue(FUNCT_MULTU, 2'b11, 2'b11, 32'hFFFFFFFE, 32'h00000003);
      @(negedge clk);
      clear_req();
      #1;
      total_cnt++; if (hi !== 32'h00000002) $display("FAIL multu_hi: got %h want %h", hi, 32'h00000002); else pass_cnt++;
      total_cnt++; if (lo !== 32'hFFFFFFFA) $display("FAIL multu_lo: got %h want %h", lo, 32'hFFFFFFFA); else pass_cnt++;
      total_cnt++; if (busy !== 1'b0) $display("FAIL multu_busy: got %b want 0", busy); else pass_cnt++;
   endtask

   task automatic test_move();
      @(negedge clk);
      issue(FUNCT_MTLO, 2'b00, 2'b11, 32'hCAFEF00D, 32'h0);
      @(negedge clk);
      clear_req();
      #1;
      total_cnt++; if (lo !== 32'hCAFEF00D) $display("FAIL mtlo_lo: got %h want %h", lo, 32'hCAFEF00D); else pass_cnt++;
      total_cnt++; if (hi !== 32'h00000002) $display("FAIL mtlo_hi_kept: got %h want %h", hi, 32'h00000002); else pass_cnt++;
   endtask

   task automatic test_div_signed();
      int cyc, sbad, hmov;
      @(negedge clk);
      run_div(FUNCT_DIV, 32'hFFFFFFF9, 32'h00000002, 1, cyc, sbad, hmov);
      total_cnt++; if (cyc != 33) $display("FAIL div_busy_cycles: got %0d want 33", cyc); else pass_cnt++;
      total_cnt++; if (sbad != 0) $display("FAIL div_mfhi_stall: %0d cycles without stall, want 0", sbad); else pass_cnt++;
      total_cnt++; if (stall !== 1'b0) $display("FAIL div_idle_stall: got %b want 0", stall); else pass_cnt++;
      total_cnt++; if (hi !== 32'hFFFFFFFF) $display("FAIL div_hi: got %h want %h", hi, 32'hFFFFFFFF); else pass_cnt++;
      total_cnt++; if (lo !== 32'hFFFFFFFD) $display("FAIL div_lo: got %h want %h", lo, 32'hFFFFFFFD); else pass_cnt++;
      clear_req();
   endtask

   task automatic test_div_boundaries();
      int cyc, sbad, hmov;
      @(negedge clk);
      run_div(FUNCT_DIVU, 32'h00000064, 32'h0, 0, cyc, sbad, hmov);
      total_cnt++; if (lo !== 32'hFFFFFFFF) $display("FAIL divu_zero_lo: got %h want %h", lo, 32'hFFFFFFFF); else pass_cnt++;
      total_cnt++; if (hi !== 32'h00000064) $display("FAIL divu_zero_hi: got %h want %h", hi, 32'h00000064); else pass_cnt++;
      @(negedge clk);
      run_div(FUNCT_DIV, 32'h80000000, 32'hFFFFFFFF, 0, cyc, sbad, hmov);
      total_cnt++; if (lo !== 32'h80000000) $display("FAIL div_ovf_lo: got %h want %h", lo, 32'h80000000); else pass_cnt++;
      total_cnt++; if (hi !== 32'h00000000) $display("FAIL div_ovf_hi: got %h want %h", hi, 32'h00000000); else pass_cnt++;
   endtask

   task automatic test_mthi_during_div();
      int cyc, sbad, hmov;
      @(negedge clk);
      // 100 / 7 = 14 remainder 2
      run_div(FUNCT_DIVU, 32'd100, 32'd7, 2, cyc, sbad, hmov);
      total_cnt++; if (sbad != 0) $display("FAIL mthi_stall: %0d cycles without stall, want 0", sbad); else pass_cnt++;
      total_cnt++; if (hmov != 0) $display("FAIL mthi_hi_held: hi changed in %0d busy cycles, want 0", hmov); else pass_cnt++;
      total_cnt++; if (hi !== 32'd2) $display("FAIL mthi_div_hi: got %h want %h", hi, 32'd2); else pass_cnt++;
      total_cnt++; if (stall !== 1'b0) $display("FAIL mthi_idle_stall: got %b want 0", stall); else pass_cnt++;
      // MTHI is still presented and is accepted at this edge
      @(negedge clk);
      clear_req();
      #1;
      total_cnt++; if (hi !== 32'h12345678) $display("FAIL mthi_hi: got %h want %h", hi, 32'h12345678); else pass_cnt++;
      total_cnt++; if (lo !== 32'd14) $display("FAIL mthi_lo_kept: got %h want %h", lo, 32'd14); else pass_cnt++;
   endtask

   task automatic test_reset_mid_div();
      @(negedge clk);
      issue(FUNCT_DIV, 2'b11, 2'b11, 32'hFFFFFFF9, 32'h00000002);
      @(negedge clk);
      clear_req();
      repeat (9) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #1;
      total_cnt++; if (hi !== 32'h0) $display("FAIL rst_mid_hi: got %h want %h", hi, 32'h0); else pass_cnt++;
      total_cnt++; if (lo !== 32'h0) $display("FAIL rst_mid_lo: got %h want %h", lo, 32'h0); else pass_cnt++;
      total_cnt++; if (busy !== 1'b0) $display("FAIL rst_mid_busy: got %b want 0", busy); else pass_cnt++;
      total_cnt++; if (state_o !== IDLE) $display("FAIL rst_mid_state: got %0d want %0d", state_o, IDLE); else pass_cnt++;
      @(negedge clk);
      issue(FUNCT_MULT, 2'b11, 2'b11, 32'd3, 32'd5);
      @(negedge clk);
      clear_req();
      #1;
      total_cnt++; if (lo !== 32'd15) $display("FAIL rst_mult_lo: got %h want %h", lo, 32'd15); else pass_cnt++;
      total_cnt++; if (hi !== 32'd0) $display("FAIL rst_mult_hi: got %h want %h", hi, 32'd0); else pass_cnt++;
   endtask

   task automatic test_clk_en();
      int cyc, sbad, hmov;
      @(negedge clk);
      clk_en = 1'b0;
      issue(FUNCT_MULT, 2'b11, 2'b11, 32'd7, 32'd9);
      repeat (2) @(negedge clk);
      #1;
      total_cnt++; if (lo !== 32'd15) $display("FAIL clken_lo: got %h want %h", lo, 32'd15); else pass_cnt++;
      total_cnt++; if (hi !== 32'd0) $display("FAIL clken_hi: got %h want %h", hi, 32'd0); else pass_cnt++;
      total_cnt++; if (stall !== 1'b0) $display("FAIL clken_stall: got %b want 0", stall); else pass_cnt++;
      clear_req();
      clk_en = 1'b1;
      @(negedge clk);
      // 1000 / 10 = 100 remainder 0
      run_div(FUNCT_DIVU, 32'd1000, 32'd10, 3, cyc, sbad, hmov);
      total_cnt++; if (cyc != 33) $display("FAIL clken_div_cycles: got %0d want 33", cyc); else pass_cnt++;
      total_cnt++; if (lo !== 32'd100) $display("FAIL clken_div_lo: got %h want %h", lo, 32'd100); else pass_cnt++;
      total_cnt++; if (hi !== 32'd0) $display("FAIL clken_div_hi: got %h want %h", hi, 32'd0); else pass_cnt++;
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_mult();
      test_move();
      test_div_signed();
      test_div_boundaries();
      test_mthi_during_div();
      test_reset_mid_div();
      test_clk_en();
      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", pass_cnt, total_cnt);
      $fatal(1, "timeout");
   end

endmodule
